// File: rtl/sfx_request_arbiter.sv
// sfx_request_arbiter: fixed-priority sound-effect request arbiter.
// Latches one-shot SFX strobes and follows held loop levels. Drives a one-hot
// select with a silent gap between clips, and handles preemption, mute and a
// play watchdog.
//
// Ports:
//   Clk          system clock, all logic on posedge
//   Reset_n      synchronous active-low reset
//   Req          one-shot strobes, or held levels for LOOP_MASK bits
//   Audio_Done   1-cycle pulse when a non-loop clip ends
//   Mute         level; forces silence and flushes queued requests
//   Sound_Select registered one-hot clip select (0 = silence)
//   Busy         registered, high whenever not idle
//   Cur_Idx      index of clip in gap/play/loop, 0 when idle
module sfx_request_arbiter #(
  parameter int          N_SFX      = 18,
  parameter logic [N_SFX-1:0] LOOP_MASK = 18'h00480,
  parameter int          GAP_CYCLES = 4,
  parameter logic [31:0] WATCHDOG   = 32'd0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [N_SFX-1:0] Req,
  input  logic             Audio_Done,
  input  logic             Mute,
  output logic [N_SFX-1:0] Sound_Select,
  output logic             Busy,
  output logic [4:0]       Cur_Idx
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_LOOP = 2'd3;

  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  logic [1:0]       state_q, state_n;
  logic [N_SFX-1:0] pend_q, pend_n;
  logic [4:0]       cur_q, cur_n;
  logic [GW-1:0]    gap_q, gap_n;
  logic [31:0]      wdog_q, wdog_n;
  logic [N_SFX-1:0] sel_q;
  logic             busy_q;

  logic [N_SFX-1:0] req_os;
  logic [N_SFX-1:0] req_lp;
  logic [N_SFX-1:0] pe;
  logic [4:0]       win;
  logic             win_v;
  logic [4:0]       lwin;
  logic             lwin_v;
  logic             wd_hit;

  function automatic logic [4:0] lowest(
    input logic [N_SFX-1:0] v
  );
    logic [4:0] r;
    r = '0;
    for (int i = N_SFX - 1; i >= 0; i--) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

  function automatic logic [N_SFX-1:0] oh(
    input logic [4:0] i
  );
    logic [N_SFX-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return one << i;
  endfunction

  // Request views with mute applied; mute makes Req invisible.
  always_comb begin
    req_os = '0;
    req_lp = '0;
    if (!Mute) begin
      req_os = Req & ~LOOP_MASK;
      req_lp = Req & LOOP_MASK;
    end
  end

  // Effective pending set: queued strobes plus this cycle's strobes.
  // A strobe for the clip already in gap/play is swallowed.
  always_comb begin
    pe = pend_q | req_os;
    if (state_q == S_GAP || state_q == S_PLAY) begin
      pe = pe & ~oh(cur_q);
    end
  end

  assign win    = lowest(pe);
  assign win_v  = |pe;
  assign lwin   = lowest(req_lp);
  assign lwin_v = |req_lp;
  assign wd_hit = (WATCHDOG != 32'd0) &&
                  (wdog_q == WATCHDOG - 32'd1);

  always_comb begin
    state_n = state_q;
    pend_n  = pe;
    cur_n   = cur_q;
    gap_n   = gap_q;
    wdog_n  = wdog_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_v) begin
          cur_n   = win;
          pend_n  = pe & ~oh(win);
          gap_n   = GAP_LOAD;
          state_n = S_GAP;
        end else if (lwin_v) begin
          cur_n   = lwin;
          gap_n   = GAP_LOAD;
          state_n = S_GAP;
        end
      end

      S_GAP: begin
        if (win_v && (win < cur_q)) begin
          // Retarget; a displaced one-shot goes back in the queue.
          cur_n  = win;
          pend_n = (pe & ~oh(win)) |
                   (oh(cur_q) & ~LOOP_MASK);
          gap_n  = GAP_LOAD;
        end else if (gap_q == '0) begin
          wdog_n  = '0;
          state_n = LOOP_MASK[cur_q] ? S_LOOP : S_PLAY;
        end else begin
          gap_n = gap_q - GW'(1);
        end
      end

      S_PLAY: begin
        // Preempt beats Audio_Done; old clip is discarded.
        if (win_v && (win < cur_q)) begin
          cur_n   = win;
          pend_n  = pe & ~oh(win);
          gap_n   = GAP_LOAD;
          state_n = S_GAP;
        end else if (Audio_Done || wd_hit) begin
          cur_n   = '0;
          state_n = S_IDLE;
        end else begin
          wdog_n = wdog_q + 32'd1;
        end
      end

      S_LOOP: begin
        if (!req_lp[cur_q]) begin
          cur_n   = '0;
          state_n = S_IDLE;
        end else if (win_v) begin
          // Still-held loop comes back later through IDLE.
          cur_n   = win;
          pend_n  = pe & ~oh(win);
          gap_n   = GAP_LOAD;
          state_n = S_GAP;
        end else if (lwin < cur_q) begin
          cur_n   = lwin;
          gap_n   = GAP_LOAD;
          state_n = S_GAP;
        end
      end

      default: begin
        cur_n   = '0;
        state_n = S_IDLE;
      end
    endcase

    if (Mute) begin
      state_n = S_IDLE;
      pend_n  = '0;
      cur_n   = '0;
      gap_n   = '0;
      wdog_n  = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      cur_q   <= '0;
      gap_q   <= '0;
      wdog_q  <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      pend_q  <= pend_n;
      cur_q   <= cur_n;
      gap_q   <= gap_n;
      wdog_q  <= wdog_n;
      if (state_n == S_PLAY || state_n == S_LOOP) begin
        sel_q <= oh(cur_n);
      end else begin
        sel_q <= '0;
      end
      busy_q <= (state_n != S_IDLE);
    end
  end

  assign Sound_Select = sel_q;
  assign Busy         = busy_q;
  assign Cur_Idx      = cur_q;

endmodule
